// File: rtl/jk_bank_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// jk_bank_sequencer
//
// Command-driven controller for an external bank of WIDTH JK flip-flops that
// shares this block's clock. A single command is accepted over a valid/ready
// handshake. The controller drives per-bit J/K for one clock edge per step.
// It then reads the bank's Q back and compares it with the value the command
// should have produced.
//
// Commands (cmd_op):
//   0 NOP    check that the bank held its value
//   1 SET    J=mask, K=0          -> Q | mask
//   2 CLR    J=0,    K=mask       -> Q & ~mask
//   3 TOG    J=mask, K=mask       -> Q ^ mask
//   4 LOAD   J=data, K=~data      -> data
//   5 COUNT  cmd_count increments, each a DRIVE+WAIT pair -> Q + count
//   6/7      illegal: no drive, error flagged at completion
//
// Ports:
//   clock      rising-edge clock, shared with the JK bank
//   reset      synchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  controller idle and able to accept (= ~busy)
//   cmd_op     operation code (see above)
//   cmd_data   bit mask (SET/CLR/TOG) or load value (LOAD)
//   cmd_count  number of +1 steps (COUNT only)
//   q_fb       Q outputs of the JK bank
//   j, k       registered J/K drive to the bank; zero outside DRIVE
//   busy       high in every state except IDLE
//   done       one-cycle pulse while the controller is in CHECK
//   error      result of the last check; cleared when a command is accepted
// ----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SET   = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_TOG   = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_COUNT = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             error_q, error_d;
    logic             illegal_q, illegal_d;

    // Toggle mask for a ripple increment. Bit i flips when every lower bit
    // is already 1. Bit 0 always flips. With all ones, every bit flips,
    // which gives the wrap to zero.
    function automatic logic [WIDTH-1:0] carryMask(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] t;
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
        return t;
    endfunction

    // State register plus all datapath registers. Reset is synchronous and
    // aborts any command in flight. J/K return to zero on the next cycle, so
    // the bank holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            j_q       <= '0;
            k_q       <= '0;
            op_q      <= OP_NOP;
            exp_q     <= '0;
            steps_q   <= '0;
            error_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            op_q      <= op_d;
            exp_q     <= exp_d;
            steps_q   <= steps_d;
            error_q   <= error_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and datapath logic. J/K are computed on the edge that
    // enters DRIVE, so they are registered and present for the whole DRIVE
    // cycle. The bank samples them on the edge that leaves DRIVE. In every
    // other cycle J/K default to zero.
    always_comb begin
        state_d   = state_q;
        j_d       = '0;
        k_d       = '0;
        op_d      = op_q;
        exp_d     = exp_q;
        steps_d   = steps_q;
        error_d   = error_q;
        illegal_d = illegal_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    steps_d   = cmd_count;
                    error_d   = 1'b0;
                    illegal_d = 1'b0;
                    // NOP, COUNT 0 and illegal ops expect the bank to hold.
                    exp_d     = q_fb;
                    case (cmd_op)
                        OP_NOP: begin
                            state_d = CHECK;
                        end
                        OP_SET: begin
                            j_d     = cmd_data;
                            exp_d   = q_fb | cmd_data;
                            state_d = DRIVE;
                        end
                        OP_CLR: begin
                            k_d     = cmd_data;
                            exp_d   = q_fb & ~cmd_data;
                            state_d = DRIVE;
                        end
                        OP_TOG: begin
                            j_d     = cmd_data;
                            k_d     = cmd_data;
                            exp_d   = q_fb ^ cmd_data;
                            state_d = DRIVE;
                        end
                        OP_LOAD: begin
                            j_d     = cmd_data;
                            k_d     = ~cmd_data;
                            exp_d   = cmd_data;
                            state_d = DRIVE;
                        end
                        OP_COUNT: begin
                            // The expected result is the plain modular sum.
                            // It is independent of how the increments ripple.
                            exp_d = q_fb + WIDTH'(cmd_count);
                            if (cmd_count == '0) begin
                                state_d = CHECK;
                            end else begin
                                j_d     = carryMask(q_fb);
                                k_d     = carryMask(q_fb);
                                state_d = DRIVE;
                            end
                        end
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = CHECK;
                        end
                    endcase
                end
            end

            DRIVE: begin
                state_d = (op_q == OP_COUNT) ? WAIT : CHECK;
            end

            // WAIT gives the bank one cycle to settle. The next toggle mask
            // is then built from the updated Q rather than the stale one.
            WAIT: begin
                steps_d = steps_q - 1'b1;
                if (steps_q > CNT_W'(1)) begin
                    j_d     = carryMask(q_fb);
                    k_d     = carryMask(q_fb);
                    state_d = DRIVE;
                end else begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                error_d = illegal_q | (q_fb != exp_q);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == CHECK);
    assign j         = j_q;
    assign k         = k_q;
    assign error     = error_q;

endmodule
